// File: rtl/pc_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package pc_fetch_pkg;

    localparam int          RegBus       = 32;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;   // addi x0, x0, 0
    localparam logic [31:0] CpuResetAddr = 32'h0000_0000;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular buffer whose slots are allocated (with their PC)
// when a fetch is granted, filled in order when data returns, and popped
// from the head. A flush drops every slot at once.
module fetch_fifo
    import pc_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc,
    input  logic [RegBus-1:0]          alloc_addr,
    input  logic                       fill,
    input  logic [RegBus-1:0]          fill_data,
    input  logic                       pop,
    output logic                       head_filled,
    output logic [RegBus-1:0]          head_addr,
    output logic [RegBus-1:0]          head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [RegBus-1:0] addr_mem [DEPTH];
    logic [RegBus-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  filled_reg;
    logic [DEPTH-1:0]  filled_next;
    logic [PW-1:0]     head_ptr_reg;
    logic [PW-1:0]     fill_ptr_reg;
    logic [PW-1:0]     tail_ptr_reg;
    logic [CW-1:0]     count_reg;

    // Per-slot filled flag; a pop of the slot being filled in the same cycle
    // (pass-through) leaves it empty.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_filled
            assign filled_next[gi] = flush                                   ? 1'b0 :
                                     (pop  && head_ptr_reg == PW'(gi))       ? 1'b0 :
                                     (fill && fill_ptr_reg == PW'(gi))       ? 1'b1 :
                                                                               filled_reg[gi];
        end
    endgenerate

    // Slot payload: address captured at grant, instruction word at return.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_mem[tail_ptr_reg] <= alloc_addr;
        end
        if (fill) begin
            data_mem[fill_ptr_reg] <= fill_data;
        end
    end

    // Pointers, filled flags and filled-entry count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filled_reg   <= '0;
            head_ptr_reg <= '0;
            fill_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            count_reg    <= '0;
        end else if (flush) begin
            filled_reg   <= filled_next;
            head_ptr_reg <= '0;
            fill_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            count_reg    <= '0;
        end else begin
            filled_reg <= filled_next;
            if (alloc) tail_ptr_reg <= tail_ptr_reg + PW'(1);
            if (fill)  fill_ptr_reg <= fill_ptr_reg + PW'(1);
            if (pop)   head_ptr_reg <= head_ptr_reg + PW'(1);
            count_reg <= count_reg + CW'(fill) - CW'(pop);
        end
    end

    assign head_filled = filled_reg[head_ptr_reg];
    assign head_addr   = addr_mem[head_ptr_reg];
    assign head_data   = data_mem[head_ptr_reg];
    assign count       = count_reg;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC, in-order req/gnt/rvalid fetch, prefetch buffer,
// redirect on jump with discard of stale in-flight returns.
// Optional feature macro: FETCH_BYPASS_EN (return word drives the outputs in
// its rvalid cycle when the buffer holds no filled entry).
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CpuResetAddr,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump,
    input  logic [31:0]       jump_addr,
    input  logic              hold,
    output logic              ibus_req,
    output logic [31:0]       ibus_addr,
    input  logic              ibus_gnt,
    input  logic              ibus_rvalid,
    input  logic [31:0]       ibus_rdata,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [31:0]       addr_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Stale returns from back-to-back redirects can stack above DEPTH.
    localparam int DW = CW + 1;

    logic [31:0]   pc_reg;
    logic [31:0]   pc_next;
    logic [CW-1:0] pend_reg;
    logic [CW-1:0] pend_next;
    logic [DW-1:0] discard_reg;
    logic [DW-1:0] discard_next;

    logic [CW-1:0] fifo_count;
    logic [CW:0]   inflight;
    logic          head_filled;
    logic [31:0]   head_addr;
    logic [31:0]   head_data;

    logic          grant;
    logic          ret_keep;
    logic          ret_drop;
    logic          bypass_hit;
    logic          out_valid;
    logic          pop;

    assign inflight  = {1'b0, fifo_count} + {1'b0, pend_reg};
    assign ibus_req  = !jump && (inflight < (CW+1)'(DEPTH));
    assign ibus_addr = pc_reg;
    assign grant     = ibus_req && ibus_gnt;
    assign ret_keep  = ibus_rvalid && (discard_reg == '0);
    assign ret_drop  = ibus_rvalid && (discard_reg != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = !head_filled && ret_keep;
`else
    assign bypass_hit = 1'b0;
`endif

    assign out_valid = (head_filled || bypass_hit) && !jump;
    assign pop       = out_valid && !hold;

    // Output mux: buffered head first, otherwise the returning word.
    always_comb begin
        inst_valid_o = out_valid;
        inst_o       = INST_NOP;
        addr_o       = ZeroWord;
        if (out_valid) begin
            inst_o = head_filled ? head_data : ibus_rdata;
            addr_o = head_addr;
        end
    end

    // Next PC and outstanding/discard counters.
    always_comb begin
        pc_next      = pc_reg;
        pend_next    = pend_reg;
        discard_next = discard_reg;
        if (jump) begin
            pc_next      = word_align(jump_addr);
            pend_next    = '0;
            discard_next = discard_reg - DW'(ret_drop) + DW'(pend_reg) - DW'(ret_keep);
        end else begin
            if (grant) pc_next = pc_reg + 32'd4;
            pend_next    = pend_reg + CW'(grant) - CW'(ret_keep);
            discard_next = discard_reg - DW'(ret_drop);
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg      <= RESET_PC;
            pend_reg    <= '0;
            discard_reg <= '0;
        end else begin
            pc_reg      <= pc_next;
            pend_reg    <= pend_next;
            discard_reg <= discard_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (jump),
        .alloc       (grant),
        .alloc_addr  (pc_reg),
        .fill        (ret_keep && !jump),
        .fill_data   (ibus_rdata),
        .pop         (pop),
        .head_filled (head_filled),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (fifo_count)
    );

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: a bus responder returns random words with
// random latency; returned words of live fetches are queued as expected
// instructions and checked when the stage presents them.
module tb_pc_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        hold = 1'b0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt = 1'b0;
    logic        ibus_rvalid = 1'b0;
    logic [31:0] ibus_rdata = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] addr_o;

    pc_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .jump(jump), .jump_addr(jump_addr), .hold(hold),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
        .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .addr_o(addr_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic stale; } fetch_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } word_t;

    fetch_t      out_q[$];    // granted fetches awaiting return, oldest first
    word_t       exp_q[$];    // returned live words not yet consumed
    int          resp_q[$];   // bus responder: cycle at which each return is due
    logic [31:0] m_pc = RST_PC;

    int checks = 0, failures = 0;
    int mcyc = 0, scyc = 0;
    int lat_lo = 1, lat_hi = 1;
    int first_valid = 0, consumed = 0, max_live = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, mcyc, act, req);
        end
    endtask

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        int          live;
        logic        exp_req, exp_valid, byp;
        logic [31:0] exp_inst, exp_addr;
        fetch_t      f;
        if (rst) begin
            chk("rst_valid", 32'(inst_valid_o), 32'd0);
            chk("rst_inst",  inst_o, NOP);
            chk("rst_addr",  addr_o, 32'd0);
            chk("rst_pc",    ibus_addr, RST_PC);
        end else begin
            mcyc++;
            live = 0;
            foreach (out_q[i]) if (!out_q[i].stale) live++;
            if (live > max_live) max_live = live;
            exp_req = !jump && ((exp_q.size() + live) < DEPTH);
            byp = 1'b0;
`ifdef FETCH_BYPASS_EN
            byp = (exp_q.size() == 0) && ibus_rvalid && (out_q.size() > 0) && !out_q[0].stale;
`endif
            exp_valid = ((exp_q.size() > 0) || byp) && !jump;
            exp_inst  = NOP;
            exp_addr  = 32'd0;
            if (exp_valid) begin
                if (exp_q.size() > 0) begin
                    exp_inst = exp_q[0].data;
                    exp_addr = exp_q[0].addr;
                end else begin
                    exp_inst = ibus_rdata;
                    exp_addr = out_q[0].addr;
                end
            end
            chk("ibus_req",   32'(ibus_req), 32'(exp_req));
            chk("ibus_addr",  ibus_addr, m_pc);
            chk("inst_valid", 32'(inst_valid_o), 32'(exp_valid));
            chk("inst",       inst_o, exp_inst);
            chk("addr",       addr_o, exp_addr);
            if (inst_valid_o && first_valid == 0) first_valid = mcyc;

            // The physical bus sees the DUT's own request.
            if (ibus_req && ibus_gnt) resp_q.push_back(mcyc + int'($urandom_range(lat_lo, lat_hi)));

            if (jump) begin
                if (ibus_rvalid && out_q.size() > 0) void'(out_q.pop_front());
                foreach (out_q[i]) out_q[i].stale = 1'b1;
                exp_q.delete();
                m_pc = jump_addr & 32'hFFFF_FFFC;
            end else begin
                if (ibus_rvalid && out_q.size() > 0) begin
                    f = out_q.pop_front();
                    if (!f.stale) exp_q.push_back('{addr: f.addr, data: ibus_rdata});
                end
                if (exp_valid && !hold && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    consumed++;
                end
                if (exp_req && ibus_gnt) begin
                    out_q.push_back('{addr: m_pc, stale: 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFF0 | $urandom_range(0, 15);
            1:       return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    // Drive one cycle of inputs, including any return that is due.
    task automatic cycle(input logic j, input logic [31:0] ja, input logic h, input logic g);
        scyc++;
        jump = j;
        jump_addr = ja;
        hold = h;
        ibus_gnt = g;
        if (resp_q.size() > 0 && resp_q[0] <= scyc) begin
            void'(resp_q.pop_front());
            ibus_rvalid = 1'b1;
            ibus_rdata = $urandom;
        end else begin
            ibus_rvalid = 1'b0;
            ibus_rdata = $urandom;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int lo, input int hi,
                       input int gnt_pct, input int hold_pct, input int jump_pct);
        lat_lo = lo;
        lat_hi = hi;
        repeat (n) cycle($urandom_range(0, 99) < jump_pct, rand_addr(),
                         $urandom_range(0, 99) < hold_pct, $urandom_range(0, 99) < gnt_pct);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single-cycle bus, no stalls.
        run(20, 1, 1, 100, 0, 0);
`ifdef FETCH_BYPASS_EN
        chk("first_valid_cycle", first_valid, 2);
`else
        chk("first_valid_cycle", first_valid, 3);
`endif
        // Three-cycle latency: outstanding fetches capped at DEPTH.
        run(20, 3, 3, 100, 0, 0);
        chk("max_outstanding", 32'(max_live <= DEPTH), 32'd1);
        chk("max_outstanding_reached", 32'(max_live), DEPTH);
        // Five-cycle stall with a full buffer, then release.
        run(3, 1, 1, 100, 0, 0);
        run(5, 1, 1, 100, 100, 0);
        run(10, 1, 1, 100, 0, 0);
        // Redirect to an unaligned target with fetches pending.
        run(4, 3, 3, 100, 0, 0);
        cycle(1'b1, 32'h0000_0103, 1'b0, 1'b1);
        run(12, 3, 3, 100, 0, 0);
        // Jump together with hold while the buffer is full.
        run(4, 1, 1, 100, 100, 0);
        cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        run(6, 1, 1, 100, 0, 0);
        // PC wrap from the top of the address space.
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        run(8, 1, 1, 100, 0, 0);
        // Randomised traffic.
        run(1500, 1, 4, 70, 30, 5);
        chk("consumed_enough", 32'(consumed > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
